// File: rtl/hand_compositor.sv
// Card-hand overlay: maps the scan position onto a row of card slots, fetches
// renderer RGB and adds a blinking highlight border. Double-banked, frame-synchronous commit.
module hand_compositor #(
  parameter int MAX_CARDS    = 15,
  parameter int CARD_W       = 30,
  parameter int CARD_H       = 50,
  parameter int PITCH        = 40,
  parameter int X0           = 170,
  parameter int Y0           = 410,
  parameter int BLINK_FRAMES = 16,
  parameter int IW           = $clog2(MAX_CARDS + 1)
) (
  input  logic          i_clk_25M,
  input  logic          i_rst,
  input  logic [9:0]    i_x_cnt,
  input  logic [9:0]    i_y_cnt,
  input  logic          i_frame_start,
  input  logic          i_wr_valid,
  input  logic [IW-1:0] i_wr_idx,
  input  logic [5:0]    i_wr_card,
  output logic          o_wr_ready,
  input  logic          i_cnt_valid,
  input  logic [IW-1:0] i_cnt,
  input  logic          i_sel_en,
  input  logic [IW-1:0] i_sel_idx,
  input  logic          i_commit,
  output logic          o_committed,
  output logic [5:0]    o_card,
  output logic [9:0]    o_lx,
  output logic [9:0]    o_ly,
  input  logic [7:0]    i_rom_r,
  input  logic [7:0]    i_rom_g,
  input  logic [7:0]    i_rom_b,
  output logic [7:0]    o_r,
  output logic [7:0]    o_g,
  output logic [7:0]    o_b
);

  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic          wr_fire;
  logic          commit_fire;
  logic [IW-1:0] cnt_clamped;
  logic [5:0]    active_w [MAX_CARDS];

  logic [IW-1:0] shadow_cnt_q, active_cnt_q;
  logic          commit_pending_q, committed_q;
  logic          sel_en_q;
  logic [IW-1:0] sel_q;
  logic [FW-1:0] frame_ctr_q;
  logic          blink_q;

  assign o_wr_ready  = !i_frame_start;
  assign wr_fire     = i_wr_valid && !i_frame_start;
  assign commit_fire = i_frame_start && (commit_pending_q || i_commit);
  assign cnt_clamped = (i_cnt > IW'(MAX_CARDS)) ? IW'(MAX_CARDS) : i_cnt;

  // Out-of-range write indices match no slot, so they are silently dropped.
  genvar gi;
  generate
    for (gi = 0; gi < MAX_CARDS; gi++) begin : g_slot
      logic [5:0] shadow_q, active_q;
      always_ff @(posedge i_clk_25M or posedge i_rst) begin
        if (i_rst) begin
          shadow_q <= '0;
          active_q <= '0;
        end else begin
          if (wr_fire && (i_wr_idx == IW'(gi))) shadow_q <= i_wr_card;
          if (commit_fire) active_q <= shadow_q;
        end
      end
      assign active_w[gi] = active_q;
    end
  endgenerate

  always_ff @(posedge i_clk_25M or posedge i_rst) begin
    if (i_rst) begin
      shadow_cnt_q     <= '0;
      active_cnt_q     <= '0;
      commit_pending_q <= 1'b0;
      committed_q      <= 1'b0;
      sel_en_q         <= 1'b0;
      sel_q            <= '0;
      frame_ctr_q      <= '0;
      blink_q          <= 1'b0;
    end else begin
      if (i_cnt_valid && !i_frame_start) shadow_cnt_q <= cnt_clamped;
      committed_q <= commit_fire;
      if (commit_fire) begin
        active_cnt_q     <= shadow_cnt_q;
        commit_pending_q <= 1'b0;
      end else if (i_commit) begin
        commit_pending_q <= 1'b1;
      end
      if (i_frame_start) begin
        sel_en_q <= i_sel_en;
        sel_q    <= i_sel_idx;
        if (frame_ctr_q == FW'(BLINK_FRAMES - 1)) begin
          frame_ctr_q <= '0;
          blink_q     <= !blink_q;
        end else begin
          frame_ctr_q <= frame_ctr_q + 1'b1;
        end
      end
    end
  end

  assign o_committed = committed_q;

  // Stage 1: geometry and slot lookup.
  logic [9:0]    dx_w, slot_w, lx_w, ly_w;
  logic          hit_d, hit_q;
  logic [IW-1:0] slot_q;
  logic [5:0]    card_d, card_q;
  logic [9:0]    lx_q, ly_q;

  assign dx_w   = i_x_cnt - 10'(X0);
  assign slot_w = dx_w / 10'(PITCH);
  assign lx_w   = dx_w % 10'(PITCH);
  assign ly_w   = i_y_cnt - 10'(Y0);
  assign hit_d  = (i_x_cnt >= 10'(X0)) && (lx_w < 10'(CARD_W)) &&
                  (slot_w < {{(10-IW){1'b0}}, active_cnt_q}) &&
                  (i_y_cnt >= 10'(Y0)) && (i_y_cnt < 10'(Y0 + CARD_H));
  assign card_d = hit_d ? active_w[slot_w[IW-1:0]] : 6'd0;

  always_ff @(posedge i_clk_25M or posedge i_rst) begin
    if (i_rst) begin
      hit_q  <= 1'b0;
      slot_q <= '0;
      card_q <= '0;
      lx_q   <= '0;
      ly_q   <= '0;
    end else begin
      hit_q  <= hit_d;
      slot_q <= slot_w[IW-1:0];
      card_q <= card_d;
      lx_q   <= hit_d ? lx_w : 10'd0;
      ly_q   <= hit_d ? ly_w : 10'd0;
    end
  end

  assign o_card = card_q;
  assign o_lx   = lx_q;
  assign o_ly   = ly_q;

  // Stage 2: colour select.
  logic border_w;
  assign border_w = hit_q && sel_en_q && blink_q && (slot_q == sel_q) &&
                    (sel_q < active_cnt_q) &&
                    ((lx_q == 10'd0) || (lx_q == 10'(CARD_W - 1)) ||
                     (ly_q == 10'd0) || (ly_q == 10'(CARD_H - 1)));

  always_ff @(posedge i_clk_25M or posedge i_rst) begin
    if (i_rst) begin
      o_r <= '0;
      o_g <= '0;
      o_b <= '0;
    end else if (!hit_q) begin
      o_r <= 8'h00;
      o_g <= 8'h00;
      o_b <= 8'h00;
    end else if (border_w) begin
      o_r <= 8'hFF;
      o_g <= 8'hFF;
      o_b <= 8'h00;
    end else begin
      o_r <= i_rom_r;
      o_g <= i_rom_g;
      o_b <= i_rom_b;
    end
  end

endmodule
